// File: rtl/apb_reg_bridge.sv
// apb_reg_bridge: APB4 slave front-end for a bank of regfield instances.
// Decodes word addresses into one-cycle write/read pulses with a merged
// write word, and returns the selected register's readback on PRDATA.

module apb_reg_bridge #(
  parameter int                 ADDR_WIDTH = 12,
  parameter int                 DATA_WIDTH = 32,
  parameter int                 REG_NUM    = 16,
  parameter int                 WAIT_CYC   = 0,
  parameter logic [REG_NUM-1:0] RO_MASK    = '0,
  parameter logic [REG_NUM-1:0] W1X_MASK   = '0
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [ADDR_WIDTH-1:0]         paddr_i,
  input  logic                          psel_i,
  input  logic                          penable_i,
  input  logic                          pwrite_i,
  input  logic [DATA_WIDTH-1:0]         pwdata_i,
  input  logic [DATA_WIDTH/8-1:0]       pstrb_i,
  output logic                          pready_o,
  output logic [DATA_WIDTH-1:0]         prdata_o,
  output logic                          pslverr_o,
  output logic [REG_NUM-1:0]            reg_wen_o,
  output logic [REG_NUM-1:0]            reg_ren_o,
  output logic [DATA_WIDTH-1:0]         reg_wdata_o,
  input  logic [REG_NUM*DATA_WIDTH-1:0] reg_rdata_i
);

  localparam int         IDX_W     = (REG_NUM > 1) ? $clog2(REG_NUM) : 1;
  localparam int         STRB_W    = DATA_WIDTH / 8;
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYC);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_DONE
  } state_t;

  state_t                  state;
  logic [3:0]              cnt;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic                    write_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic [STRB_W-1:0]       strb_q;

  logic [IDX_W-1:0]        idx;
  logic                    idx_hit;
  logic                    sel_ro;
  logic                    sel_w1x;
  logic [REG_NUM-1:0]      onehot;
  logic [DATA_WIDTH-1:0]   sel_rdata;
  logic                    upper_bad;
  logic                    err;
  logic [DATA_WIDTH-1:0]   merged;

  assign idx = addr_q[2 +: IDX_W];

  // Decode the latched address: select the register, its mask bits and readback.
  always_comb begin
    idx_hit   = 1'b0;
    sel_ro    = 1'b0;
    sel_w1x   = 1'b0;
    onehot    = '0;
    sel_rdata = '0;
    for (int i = 0; i < REG_NUM; i++) begin
      if (idx == i[IDX_W-1:0]) begin
        idx_hit   = 1'b1;
        sel_ro    = RO_MASK[i];
        sel_w1x   = W1X_MASK[i];
        onehot[i] = 1'b1;
        sel_rdata = reg_rdata_i[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
    upper_bad = (addr_q >> (2 + IDX_W)) != '0;
    err       = (addr_q[1:0] != 2'b00) | !idx_hit | upper_bad | (write_q & sel_ro);
  end

  // Build the full write word: strobed bytes from the bus, others zeroed or read-modify-written.
  always_comb begin
    merged = '0;
    for (int b = 0; b < STRB_W; b++) begin
      if (strb_q[b]) begin
        merged[b*8 +: 8] = wdata_q[b*8 +: 8];
      end else if (sel_w1x) begin
        merged[b*8 +: 8] = 8'h00;
      end else begin
        merged[b*8 +: 8] = sel_rdata[b*8 +: 8];
      end
    end
  end

  // Transfer FSM; every output is registered and only nonzero in the DONE cycle.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      addr_q      <= '0;
      write_q     <= 1'b0;
      wdata_q     <= '0;
      strb_q      <= '0;
      pready_o    <= 1'b0;
      pslverr_o   <= 1'b0;
      prdata_o    <= '0;
      reg_wen_o   <= '0;
      reg_ren_o   <= '0;
      reg_wdata_o <= '0;
    end else begin
      pready_o    <= 1'b0;
      pslverr_o   <= 1'b0;
      prdata_o    <= '0;
      reg_wen_o   <= '0;
      reg_ren_o   <= '0;
      reg_wdata_o <= '0;
      case (state)
        ST_IDLE: begin
          if (psel_i && !penable_i) begin
            addr_q  <= paddr_i;
            write_q <= pwrite_i;
            wdata_q <= pwdata_i;
            strb_q  <= pstrb_i;
            cnt     <= WAIT_INIT;
            state   <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (!psel_i) begin
            state <= ST_IDLE;
          end else if (cnt == 4'd0) begin
            state     <= ST_DONE;
            pready_o  <= 1'b1;
            pslverr_o <= err;
            if (!err) begin
              if (write_q) begin
                reg_wen_o   <= onehot;
                reg_wdata_o <= merged;
              end else begin
                reg_ren_o <= onehot;
                prdata_o  <= sel_rdata;
              end
            end
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
